// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : instruction fetch with PC, local jump resolution, IF/ID register
// Rev 1.0
// ============================================================================
module if_stage #(
  parameter int N        = 32,
  parameter int DEPTH    = 32,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic         ifid_valid,
  output logic [N-1:0] ifid_instr,
  output logic [N-1:0] ifid_pc,
  output logic         pc_oob,
  output logic [15:0]  fetch_cnt
);

  localparam logic [N:0]   c_DEPTH    = (N+1)'(DEPTH);
  localparam logic [N-1:0] c_RESET_PC = N'(RESET_PC);
  localparam logic [5:0]   c_OP_J     = 6'b000010;

  logic [N-1:0] pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] ifpc_q, ifpc_d;
  logic [15:0]  cnt_q, cnt_d;

  logic [31:0]  w_instr32;
  logic         w_oob;
  logic         w_jump;
  logic [N-1:0] w_jtarget;

  assign w_instr32 = 32'(imem_instr);
  assign w_oob     = {1'b0, pc_q} >= c_DEPTH;
  assign w_jump    = (w_instr32[31:26] == c_OP_J);
  // Jump field is a byte-style target reused directly as a word index.
  assign w_jtarget = N'({w_instr32[25:0], 2'b00});

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      instr_d = '0;
      ifpc_d  = pc_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (w_oob) begin
      valid_d = 1'b0;
      instr_d = '0;
      ifpc_d  = pc_q;
    end else begin
      pc_d    = w_jump ? w_jtarget : pc_q + N'(1);
      valid_d = 1'b1;
      instr_d = imem_instr;
      ifpc_d  = pc_q;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= c_RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc_oob     = w_oob;
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ifpc_q;
  assign fetch_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// Testbench for if_stage: ROM model plus scoreboard of expected IF/ID contents.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        pc_oob;
  logic [15:0] fetch_cnt;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] rom[0:31];

  if_stage #(.N(32), .DEPTH(32), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .pc_oob         (pc_oob),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 32) ? rom[imem_addr[4:0]] : 32'h0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.v = v; e.instr = instr; e.pc = pc;
    sbq.push_back(e);
  endtask

  task automatic apply_reset();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.delete();
  endtask

  task automatic test_reset();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc, fetch_cnt, imem_addr, pc_oob} !== {1'b0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got v=%0b instr=%h pc=%0d cnt=%0d addr=%0d oob=%0b, want all zero",
               ifid_valid, ifid_instr, ifid_pc, fetch_cnt, imem_addr, pc_oob);
    end
    rst_n = 1'b1;
    sbq.delete();
  endtask

  task automatic test_sequential();
    exp_t e;
    for (int i = 0; i < 4; i++) push(1'b1, rom[i], i);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({ifid_valid, ifid_instr, ifid_pc} !== e) begin
        fails++;
        $display("FAIL seq_fetch[%0d]: got v=%0b instr=%h pc=%0d, want v=%0b instr=%h pc=%0d",
                 i, ifid_valid, ifid_instr, ifid_pc, e.v, e.instr, e.pc);
      end
    end
    checks++;
    if (fetch_cnt !== 16'd4) begin
      fails++;
      $display("FAIL seq_fetch_cnt: got %0d, want 4", fetch_cnt);
    end
  endtask

  task automatic test_jump();
    exp_t e;
    push(1'b1, rom[4], 4);
    push(1'b1, 32'h08000004, 5);
    push(1'b1, 32'h8C010001, 16);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({ifid_valid, ifid_instr, ifid_pc} !== e) begin
        fails++;
        $display("FAIL jump[%0d]: got v=%0b instr=%h pc=%0d, want v=%0b instr=%h pc=%0d",
                 i, ifid_valid, ifid_instr, ifid_pc, e.v, e.instr, e.pc);
      end
    end
    checks++;
    if (fetch_cnt !== 16'd7 || imem_addr !== 32'd17) begin
      fails++;
      $display("FAIL jump_cnt_addr: got cnt=%0d addr=%0d, want cnt=7 addr=17", fetch_cnt, imem_addr);
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    apply_reset();
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (imem_addr !== 32'd3) begin
      fails++;
      $display("FAIL redir_pre_addr: got %0d, want 3", imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd6;
    push(1'b0, 32'h0, 3);
    push(1'b1, rom[6], 6);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    e = sbq.pop_front();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc} !== e || fetch_cnt !== 16'd3) begin
      fails++;
      $display("FAIL redir_bubble: got v=%0b instr=%h pc=%0d cnt=%0d, want v=0 instr=0 pc=%0d cnt=3",
               ifid_valid, ifid_instr, ifid_pc, fetch_cnt, e.pc);
    end
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc} !== e || fetch_cnt !== 16'd4) begin
      fails++;
      $display("FAIL redir_target: got v=%0b instr=%h pc=%0d cnt=%0d, want v=1 instr=%h pc=6 cnt=4",
               ifid_valid, ifid_instr, ifid_pc, fetch_cnt, e.instr);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    apply_reset();
    repeat (2) begin @(posedge clk); #1; end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ifid_pc !== 32'd1 || ifid_instr !== rom[1] || fetch_cnt !== 16'd2 || imem_addr !== 32'd2) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got pc=%0d instr=%h cnt=%0d addr=%0d, want pc=1 instr=%h cnt=2 addr=2",
                 i, ifid_pc, ifid_instr, fetch_cnt, imem_addr, rom[1]);
      end
    end
    stall = 1'b0;
    push(1'b1, rom[2], 2);
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc} !== e) begin
      fails++;
      $display("FAIL stall_release: got v=%0b instr=%h pc=%0d, want v=1 instr=%h pc=2",
               ifid_valid, ifid_instr, ifid_pc, e.instr);
    end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd16;
    push(1'b0, 32'h0, 3);
    push(1'b1, rom[16], 16);
    @(posedge clk); #1;
    stall = 1'b0; redirect_valid = 1'b0;
    e = sbq.pop_front();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc} !== e || imem_addr !== 32'd16) begin
      fails++;
      $display("FAIL stall_redir_flush: got v=%0b instr=%h pc=%0d addr=%0d, want v=0 instr=0 pc=3 addr=16",
               ifid_valid, ifid_instr, ifid_pc, imem_addr);
    end
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc} !== e) begin
      fails++;
      $display("FAIL stall_redir_target: got v=%0b instr=%h pc=%0d, want v=1 instr=%h pc=16",
               ifid_valid, ifid_instr, ifid_pc, e.instr);
    end
  endtask

  task automatic test_oob();
    exp_t        e;
    logic [15:0] cnt0;
    cnt0 = fetch_cnt;
    redirect_valid = 1'b1; redirect_pc = 32'd40;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    checks++;
    if (pc_oob !== 1'b1 || imem_addr !== 32'd40 || ifid_valid !== 1'b0) begin
      fails++;
      $display("FAIL oob_enter: got oob=%0b addr=%0d v=%0b, want oob=1 addr=40 v=0", pc_oob, imem_addr, ifid_valid);
    end
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 32'h0, 40);
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({ifid_valid, ifid_instr, ifid_pc} !== e || imem_addr !== 32'd40 || pc_oob !== 1'b1 || fetch_cnt !== cnt0) begin
        fails++;
        $display("FAIL oob_park[%0d]: got v=%0b instr=%h pc=%0d addr=%0d oob=%0b cnt=%0d, want v=0 instr=0 pc=40 addr=40 oob=1 cnt=%0d",
                 i, ifid_valid, ifid_instr, ifid_pc, imem_addr, pc_oob, fetch_cnt, cnt0);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    push(1'b0, 32'h0, 40);
    push(1'b1, rom[0], 0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    e = sbq.pop_front();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc} !== e || pc_oob !== 1'b0) begin
      fails++;
      $display("FAIL oob_recover_flush: got v=%0b pc=%0d oob=%0b, want v=0 pc=40 oob=0", ifid_valid, ifid_pc, pc_oob);
    end
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc} !== e) begin
      fails++;
      $display("FAIL oob_recover_fetch: got v=%0b instr=%h pc=%0d, want v=1 instr=%h pc=0",
               ifid_valid, ifid_instr, ifid_pc, e.instr);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    redirect_valid = 1'b1; redirect_pc = 32'd18;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (imem_addr !== 32'd19 || ifid_pc !== 32'd18 || ifid_valid !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre: got addr=%0d pc=%0d v=%0b, want addr=19 pc=18 v=1", imem_addr, ifid_pc, ifid_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifid_valid, ifid_instr, ifid_pc, fetch_cnt, imem_addr, pc_oob} !== {1'b0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL areset_immediate: got v=%0b instr=%h pc=%0d cnt=%0d addr=%0d oob=%0b, want all zero",
               ifid_valid, ifid_instr, ifid_pc, fetch_cnt, imem_addr, pc_oob);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.delete();
    push(1'b1, rom[0], 0);
    push(1'b1, rom[1], 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = sbq.pop_front();
      checks++;
      if ({ifid_valid, ifid_instr, ifid_pc} !== e || fetch_cnt !== 16'(i + 1)) begin
        fails++;
        $display("FAIL areset_restart[%0d]: got v=%0b instr=%h pc=%0d cnt=%0d, want v=1 instr=%h pc=%0d cnt=%0d",
                 i, ifid_valid, ifid_instr, ifid_pc, fetch_cnt, e.instr, e.pc, i + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | (32'(i) * 32'h0001_0101);
    rom[5]  = 32'h0800_0004;
    rom[16] = 32'h8C01_0001;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    test_reset();
    test_sequential();
    test_jump();
    test_redirect();
    test_stall();
    test_oob();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the single-cycle/pipelined MIPS-style core. It owns the program counter and drives the word address into the combinational instruction ROM. It resolves unconditional jumps (opcode 2) locally and accepts redirects from the execute stage for taken branches. Each fetched word is registered into the IF/ID pipeline register, with stall and flush support and a fetch counter for performance checks.

## Interface

Parameters:
- N, 32: datapath / address width.
- DEPTH, 32: number of words in the instruction ROM. Valid word addresses are 0..DEPTH-1.
- RESET_PC, 0: word address fetched first after reset.

Ports:
- clk, input, 1: rising-edge clock, the single clock for the block.
- rst_n, input, 1: reset, asynchronous and active-low.
- imem_addr, output, N: word address to the ROM. Combinationally equal to pc.
- imem_instr, input, N: instruction word returned combinationally by the ROM for imem_addr.
- stall, input, 1: hazard hold. When high, pc and IF/ID hold their values.
- redirect_valid, input, 1: a taken branch from the execute stage.
- redirect_pc, input, N: word address of the branch target.
- ifid_valid, output, 1: IF/ID holds a real instruction.
- ifid_instr, output, N: registered instruction word. Holds 0 (nop) when not valid.
- ifid_pc, output, N: word address that the registered instruction was fetched from.
- pc_oob, output, 1: combinational, high when pc >= DEPTH.
- fetch_cnt, output, 16: count of valid instructions loaded into IF/ID. Saturates at 16'hFFFF.

## Operation

- pc is a word index, not a byte address. Sequential next-PC is pc+1, computed modulo 2^N.
- Jump decode is applied to imem_instr. When imem_instr[31:26]==6'b000010 and the fetch is in range, the jump target is {imem_instr[25:0],2'b00}, zero-extended or truncated to N bits, and used as a word index. Example: address field 4 gives target 16.
- The jump instruction itself is loaded into IF/ID as valid. The following fetch comes from the target, so there is no bubble.
- Next-state priority, evaluated per rising edge:
  1. rst_n low: pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc=0, fetch_cnt=0. This applies asynchronously, including mid-operation; any in-flight fetch is discarded.
  2. redirect_valid: pc<=redirect_pc. IF/ID is flushed (ifid_valid<=0, ifid_instr<=0, ifid_pc<=pc). Redirect takes priority over stall.
  3. stall: pc, IF/ID and fetch_cnt all hold.
  4. pc_oob: pc holds. IF/ID is loaded with a bubble (valid 0, instr 0, ifid_pc<=pc). No jump decode is applied.
  5. jump decoded: pc<=jump target. IF/ID<=valid, imem_instr, pc.
  6. Otherwise: pc<=pc+1. IF/ID<=valid, imem_instr, pc.
- fetch_cnt increments only on cases 5 and 6, and stops at 16'hFFFF.
- The block holds no other state. There is no branch prediction; beq resolves downstream and returns through redirect.

## Timing

- Fetch latency is 1 cycle. The word at pc appears on ifid_instr after the next rising edge.
- imem_addr and pc_oob change only after a clock edge or reset, never combinationally from other inputs.
- Taken-branch penalty is 1 bubble: the cycle after redirect_valid, ifid_valid=0; on the following cycle, IF/ID holds the word at redirect_pc.
- Jump penalty is 0 cycles.
- Reset release: the first edge with rst_n high loads word RESET_PC into IF/ID.
- redirect_valid and stall asserted together: the redirect is taken, and the stall is ignored for that edge.
- Wrap-around: pc = 2^N-1 advances to 0 only if that pc is in range. Otherwise it parks with pc_oob=1 until a redirect or reset.

## Test plan

- Reset, then 4 free-running cycles with ROM words 0..3 loaded → ifid_pc = 0,1,2,3 in turn, ifid_instr matches memory[0..3], ifid_valid=1, fetch_cnt=4.
- pc reaches 5 holding 32'h08000004 (j 4) → IF/ID holds the jump with ifid_pc=5. The next cycle gives ifid_pc=16 with the lw word (32'h8C010001), and there is no bubble.
- redirect_valid=1, redirect_pc=6 while pc=3 → next cycle ifid_valid=0 and ifid_instr=0. The cycle after that gives ifid_pc=6 and the word at 6. fetch_cnt does not count the bubble.
- stall held for 3 cycles at pc=2 → ifid_pc, ifid_instr, fetch_cnt and imem_addr are unchanged. Release gives ifid_pc=2 on the next edge. With stall and redirect (pc=16) asserted together, pc=16 is taken.
- Redirect to pc=40 with DEPTH=32 → pc_oob=1, ifid_valid stays 0 every cycle, pc stays 40. A redirect to 0 then recovers.
- Assert rst_n low mid-run, asynchronous to clk, at pc=18 → all outputs reach reset values immediately. After release, fetch restarts at RESET_PC.
